usb_packet_tx: RTL and testbench

Transmit-side packet framer for the FT245-style USB FIFO link. It takes a byte stream from the register/RAM side and writes one framed packet into the FT chip: header key symbols, payload, optional checksum, then trailer key symbols. It is the write-direction counterpart of the packet receiver in `USB_RAM_Reg`, and it drives `FT_WR`/`FT_DATA_Out` under `FT_TXEn` flow control.

---
 rtl/usb_packet_tx_if.sv | 11 +
 rtl/usb_packet_tx.sv | 223 ++++++++++++++++++++++
 tb/tb_usb_packet_tx.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_packet_tx_if.sv
// usb_packet_tx_if: payload byte-stream handshake between the register/RAM
// side (master, the byte source) and the USB packet framer (slave).
interface usb_packet_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
    modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/usb_packet_tx.sv
// usb_packet_tx: frames a payload byte stream into one FT245 write packet
// (header keys, payload, optional checksum, trailer keys) and drives the
// FT_WR strobe under FT_TXEn flow control.
// Optional feature: define USB_TX_CHECKSUM_EN to append a mod-256 payload
// checksum byte between the payload and the trailer.
module usb_packet_tx #(
    parameter logic [7:0] HEADER_KEY_SYMBOL         = 8'd85,
    parameter int         HEADER_KEY_SYMBOL_NUMBER  = 12,
    parameter logic [7:0] TRAILER_KEY_SYMBOL        = 8'd170,
    parameter int         TRAILER_KEY_SYMBOL_NUMBER = 8,
    parameter int         WR_SETUP                  = 2,
    parameter int         WR_PULSE                  = 4,
    parameter int         WR_GAP                    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               FT_TXEn,
    output logic               FT_WR,
    output logic [7:0]         FT_DATA_Out,
    output logic               FT_DATA_Oe,
    usb_packet_tx_if.slave     tx,
    output logic               busy,
    output logic               packet_done
);

    localparam int CNT_MAX = (HEADER_KEY_SYMBOL_NUMBER > TRAILER_KEY_SYMBOL_NUMBER) ?
                             HEADER_KEY_SYMBOL_NUMBER : TRAILER_KEY_SYMBOL_NUMBER;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int TMR_A   = (WR_SETUP > WR_PULSE) ? WR_SETUP : WR_PULSE;
    localparam int TMR_MAX = (TMR_A > WR_GAP) ? TMR_A : WR_GAP;
    localparam int TW      = $clog2(TMR_MAX + 1);

    localparam logic [CW-1:0] HDR_LAST    = CW'(HEADER_KEY_SYMBOL_NUMBER - 1);
    localparam logic [CW-1:0] TRL_LAST    = CW'(TRAILER_KEY_SYMBOL_NUMBER - 1);
    localparam logic [TW-1:0] SETUP_LAST  = TW'(WR_SETUP - 1);
    localparam logic [TW-1:0] PULSE_LAST  = TW'(WR_PULSE - 1);
    localparam logic [TW-1:0] GAP_LAST    = TW'(WR_GAP - 1);

    typedef enum logic [2:0] {
        PH_IDLE, PH_HEADER, PH_PAYLOAD, PH_CHECKSUM, PH_TRAILER
    } phase_t;

    typedef enum logic [2:0] {
        SB_LOAD, SB_WAIT_TXE, SB_SETUP, SB_STROBE, SB_GAP
    } sub_t;

    phase_t        phase_reg, phase_next;
    sub_t          sub_reg, sub_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [TW-1:0] tmr_reg, tmr_next;
    logic          done_reg, done_next;
    logic [1:0]    txe_sync_reg;
    logic [7:0]    data_reg;
    logic          last_reg;
    logic          txe_synced;
    logic          accept;

    assign txe_synced = txe_sync_reg[1];
    // A payload byte is taken only while parked in PAYLOAD/LOAD with data offered.
    assign accept     = (phase_reg == PH_PAYLOAD) && (sub_reg == SB_LOAD) && tx.tx_valid;

    // Two-flop synchronizer for the asynchronous FIFO-full flag; resets to "full".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) txe_sync_reg <= 2'b11;
        else     txe_sync_reg <= {txe_sync_reg[0], FT_TXEn};
    end

    // State register: phase, per-byte substate, byte and cycle counters, done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_reg <= PH_IDLE;
            sub_reg   <= SB_LOAD;
            cnt_reg   <= '0;
            tmr_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            phase_reg <= phase_next;
            sub_reg   <= sub_next;
            cnt_reg   <= cnt_next;
            tmr_reg   <= tmr_next;
            done_reg  <= done_next;
        end
    end

    // Next-state logic: walk LOAD/WAIT_TXE/SETUP/STROBE/GAP per byte, advance phases on GAP end.
    always_comb begin
        phase_next = phase_reg;
        sub_next   = sub_reg;
        cnt_next   = cnt_reg;
        tmr_next   = tmr_reg;
        done_next  = 1'b0;
        if (phase_reg == PH_IDLE) begin
            sub_next = SB_LOAD;
            tmr_next = '0;
            if (tx.tx_valid) begin
                phase_next = PH_HEADER;
                cnt_next   = '0;
            end
        end else begin
            case (sub_reg)
                SB_LOAD: begin
                    if ((phase_reg != PH_PAYLOAD) || tx.tx_valid)
                        sub_next = SB_WAIT_TXE;
                end
                SB_WAIT_TXE: begin
                    tmr_next = '0;
                    if (!txe_synced)
                        sub_next = SB_SETUP;
                end
                SB_SETUP: begin
                    if (tmr_reg == SETUP_LAST) begin
                        sub_next = SB_STROBE;
                        tmr_next = '0;
                    end else begin
                        tmr_next = tmr_reg + 1'b1;
                    end
                end
                SB_STROBE: begin
                    if (tmr_reg == PULSE_LAST) begin
                        sub_next = SB_GAP;
                        tmr_next = '0;
                    end else begin
                        tmr_next = tmr_reg + 1'b1;
                    end
                end
                SB_GAP: begin
                    if (tmr_reg == GAP_LAST) begin
                        sub_next = SB_LOAD;
                        tmr_next = '0;
                        case (phase_reg)
                            PH_HEADER: begin
                                if (cnt_reg == HDR_LAST) begin
                                    phase_next = PH_PAYLOAD;
                                    cnt_next   = '0;
                                end else begin
                                    cnt_next = cnt_reg + 1'b1;
                                end
                            end
                            PH_PAYLOAD: begin
                                if (last_reg) begin
`ifdef USB_TX_CHECKSUM_EN
                                    phase_next = PH_CHECKSUM;
`else
                                    phase_next = PH_TRAILER;
`endif
                                    cnt_next = '0;
                                end
                            end
`ifdef USB_TX_CHECKSUM_EN
                            PH_CHECKSUM: begin
                                phase_next = PH_TRAILER;
                                cnt_next   = '0;
                            end
`endif
                            PH_TRAILER: begin
                                if (cnt_reg == TRL_LAST) begin
                                    phase_next = PH_IDLE;
                                    cnt_next   = '0;
                                    done_next  = 1'b1;
                                end else begin
                                    cnt_next = cnt_reg + 1'b1;
                                end
                            end
                            default: phase_next = PH_IDLE;
                        endcase
                    end else begin
                        tmr_next = tmr_reg + 1'b1;
                    end
                end
                default: sub_next = SB_LOAD;
            endcase
        end
    end

    // Outputs decoded from the current state; reset forces them low at once.
    always_comb begin
        FT_WR       = (sub_reg == SB_STROBE);
        FT_DATA_Oe  = (sub_reg == SB_SETUP) || (sub_reg == SB_STROBE);
        tx.tx_ready = accept;
        busy        = (phase_reg != PH_IDLE);
        packet_done = done_reg;
    end

`ifdef USB_TX_CHECKSUM_EN
    logic [7:0] sum_reg;

    // Running payload sum; cleared when a new packet leaves IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sum_reg <= 8'd0;
        else if ((phase_reg == PH_IDLE) && tx.tx_valid)
            sum_reg <= 8'd0;
        else if (accept)
            sum_reg <= sum_reg + tx.tx_data;
    end
`endif

    // Byte register: selected in LOAD only, then held stable through GAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg <= 8'd0;
            last_reg <= 1'b0;
        end else if (sub_reg == SB_LOAD) begin
            case (phase_reg)
                PH_HEADER:  data_reg <= HEADER_KEY_SYMBOL;
                PH_PAYLOAD: begin
                    if (accept) begin
                        data_reg <= tx.tx_data;
                        last_reg <= tx.tx_last;
                    end
                end
`ifdef USB_TX_CHECKSUM_EN
                PH_CHECKSUM: data_reg <= sum_reg;
`endif
                PH_TRAILER: data_reg <= TRAILER_KEY_SYMBOL;
                default:    data_reg <= data_reg;
            endcase
        end
    end

    assign FT_DATA_Out = data_reg;

endmodule

// File: tb/tb_usb_packet_tx.sv
// tb_usb_packet_tx: randomized packet traffic against a queue-based model of
// the expected FT byte stream, with an FT FIFO model driving FT_TXEn.
module tb_usb_packet_tx;
    localparam int HN = 12;
    localparam int TN = 8;
    localparam int WR_SETUP = 2;
    localparam int WR_PULSE = 4;
    localparam int WR_GAP = 4;
    localparam int BYTE_PERIOD = 1 + 1 + WR_SETUP + WR_PULSE + WR_GAP;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       FT_TXEn;
    logic       FT_WR;
    logic [7:0] FT_DATA_Out;
    logic       FT_DATA_Oe;
    logic       busy;
    logic       packet_done;

    usb_packet_tx_if txi ();

    usb_packet_tx #(
        .HEADER_KEY_SYMBOL         (8'd85),
        .HEADER_KEY_SYMBOL_NUMBER  (HN),
        .TRAILER_KEY_SYMBOL        (8'd170),
        .TRAILER_KEY_SYMBOL_NUMBER (TN),
        .WR_SETUP                  (WR_SETUP),
        .WR_PULSE                  (WR_PULSE),
        .WR_GAP                    (WR_GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .FT_TXEn     (FT_TXEn),
        .FT_WR       (FT_WR),
        .FT_DATA_Out (FT_DATA_Out),
        .FT_DATA_Oe  (FT_DATA_Oe),
        .tx          (txi.slave),
        .busy        (busy),
        .packet_done (packet_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    logic [7:0] rx_q[$];
    logic [7:0] pay_q[$];
    int  cyc = 0;
    int  done_cnt = 0;
    int  done_cyc = 0;
    int  busy_rise = 0;
    int  rise_cnt = 0;
    bit  ft_en = 1'b0;
    int  ft_hold = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    // Bus monitor and FT FIFO model: captures bytes on FT_WR falls, raises
    // FT_TXEn after each write and drops it ft_hold cycles later.
    initial begin
        logic prev_wr;
        logic prev_busy;
        int   ft_left;
        prev_wr = 1'b0;
        prev_busy = 1'b0;
        ft_left = 0;
        FT_TXEn = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (FT_WR && !prev_wr) begin
                rise_cnt++;
                if (ft_en) chk("txen_low_at_strobe", int'(FT_TXEn), 0);
                chk("oe_at_strobe", int'(FT_DATA_Oe), 1);
            end
            if (!FT_WR && prev_wr) begin
                rx_q.push_back(FT_DATA_Out);
                if (ft_en) begin
                    FT_TXEn = 1'b1;
                    ft_left = ft_hold;
                end
            end else if (FT_TXEn) begin
                if (ft_left > 0) ft_left--;
                else FT_TXEn = 1'b0;
            end
            if (!ft_en) FT_TXEn = 1'b0;
            if (busy && !prev_busy) busy_rise = cyc;
            if (packet_done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_low_at_done", int'(busy), 0);
            end
            prev_wr = FT_WR;
            prev_busy = busy;
        end
    end

    // Sends pay_q as one packet and compares the bus stream with the model.
    task automatic run_packet(input string tag, input int stall_at, input int stall_len,
                              input int valid_pct, input int ft_delay, input bit chk_lat);
        logic [7:0] exp_q[$];
        int base, dbase, idx, n, stall_left, stall_cyc, viol, guard, sum, got;
        bit acc;
        sum = 0;
        for (int i = 0; i < HN; i++) exp_q.push_back(8'h55);
        foreach (pay_q[i]) begin
            exp_q.push_back(pay_q[i]);
            sum = sum + int'(pay_q[i]);
        end
`ifdef USB_TX_CHECKSUM_EN
        exp_q.push_back(8'(sum % 256));
`endif
        for (int i = 0; i < TN; i++) exp_q.push_back(8'hAA);

        base = rx_q.size();
        dbase = done_cnt;
        ft_hold = ft_delay;
        ft_en = (ft_delay > 0);
        n = pay_q.size();
        idx = 0; acc = 1'b0; stall_left = 0; stall_cyc = 0; viol = 0; guard = 0;
        while (idx < n && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (acc) begin
                idx++;
                acc = 1'b0;
                if (idx == stall_at) begin
                    stall_left = stall_len;
                    stall_cyc = 0;
                end
            end
            if (idx >= n) break;
            if (stall_left > 0) begin
                txi.tx_valid = 1'b0;
                txi.tx_last = 1'($urandom);
                stall_left--;
                stall_cyc++;
                if (stall_cyc > 15 && (FT_WR || FT_DATA_Oe)) viol++;
            end else if ($urandom_range(99) < valid_pct) begin
                txi.tx_valid = 1'b1;
                txi.tx_data = pay_q[idx];
                txi.tx_last = (idx == n - 1);
            end else begin
                txi.tx_valid = 1'b0;
                txi.tx_data = 8'($urandom);
                txi.tx_last = 1'($urandom);
            end
            #1;
            acc = txi.tx_valid && txi.tx_ready;
        end
        txi.tx_valid = 1'b0;
        txi.tx_last = 1'b0;
        chk({tag, "_accepted"}, idx, n);

        guard = 0;
        while (done_cnt == dbase && guard < 30000) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_done_pulses"}, done_cnt - dbase, 1);
        chk({tag, "_len"}, rx_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (base + i < rx_q.size()) ? int'(rx_q[base + i]) : -1;
            chk($sformatf("%s_byte%0d", tag, i), got, int'(exp_q[i]));
        end
        if (stall_len > 0) chk({tag, "_stall_quiet"}, viol, 0);
        if (chk_lat) chk({tag, "_done_latency"}, done_cyc - busy_rise, exp_q.size() * BYTE_PERIOD);
        $display("packet %s: %0d payload bytes, %0d bus bytes", tag, n, rx_q.size() - base);
        ft_en = 1'b0;
    endtask

    initial begin
        int base, r0, guard, n;
        txi.tx_valid = 1'b0;
        txi.tx_data = 8'h00;
        txi.tx_last = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ft_wr", int'(FT_WR), 0);
        chk("rst_oe", int'(FT_DATA_Oe), 0);
        chk("rst_data", int'(FT_DATA_Out), 0);
        chk("rst_ready", int'(txi.tx_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(packet_done), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        // Single byte, FIFO always ready
        pay_q.delete(); pay_q.push_back(8'h56);
        run_packet("single", 0, 0, 100, 0, 1'b1);

        // Eight bytes with a slow FT FIFO
        pay_q.delete();
        pay_q.push_back(8'h10); pay_q.push_back(8'h00); pay_q.push_back(8'hCD); pay_q.push_back(8'hAB);
        pay_q.push_back(8'h0F); pay_q.push_back(8'hF0); pay_q.push_back(8'h34); pay_q.push_back(8'h56);
        run_packet("eight_ftfull", 0, 0, 100, 40, 1'b0);

        // Source stall after the 3rd payload byte
        pay_q.delete();
        for (int i = 0; i < 6; i++) pay_q.push_back(8'($urandom));
        run_packet("stall", 3, 100, 100, 0, 1'b0);

        // Asynchronous reset during the 5th header byte's strobe
        base = rx_q.size();
        r0 = rise_cnt;
        @(negedge clk);
        txi.tx_valid = 1'b1;
        txi.tx_data = 8'h11;
        txi.tx_last = 1'b1;
        guard = 0;
        while (rise_cnt - r0 < 5 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("rst_mid_reached", rise_cnt - r0, 5);
        chk("rst_mid_hdr_bytes", rx_q.size() - base, 4);
        @(posedge clk);
        #2;
        chk("rst_mid_pre_wr", int'(FT_WR), 1);
        rst = 1'b1;
        txi.tx_valid = 1'b0;
        #1;
        chk("rst_mid_ft_wr", int'(FT_WR), 0);
        chk("rst_mid_oe", int'(FT_DATA_Oe), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_ready", int'(txi.tx_ready), 0);
        chk("rst_mid_data", int'(FT_DATA_Out), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_idle", int'(busy), 0);
        pay_q.delete(); pay_q.push_back(8'hAB);
        run_packet("after_reset", 0, 0, 100, 0, 1'b0);

        // Checksum case (also a plain 3-byte packet when the checksum is off)
        pay_q.delete();
        pay_q.push_back(8'h01); pay_q.push_back(8'h02); pay_q.push_back(8'hFF);
        run_packet("cksum", 0, 0, 100, 0, 1'b0);

        // Random packets with random source gaps and FIFO back-pressure
        for (int p = 0; p < 6; p++) begin
            n = $urandom_range(1, 10);
            pay_q.delete();
            for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
            run_packet($sformatf("rand%0d", p), 0, 0, $urandom_range(50, 100),
                       $urandom_range(0, 30), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
